// File: rtl/pockstat_lcd_scan.sv
// pockstat_lcd_scan: scans the 32x32 1bpp LCD framebuffer out as scaled video (sync/blank/RGB) plus a vblank IRQ.
// Latency: video outputs trail hcnt/vcnt by one pixel enable; a fetched row lands in row_buf one clk after fb_rd.
// Backpressure: none; the raster is free-running and the framebuffer port must answer exactly one clk after fb_rd.
module pockstat_lcd_scan #(
  parameter int          CE_DIV   = 4,
  parameter int          SCALE    = 8,
  parameter int          H_TOTAL  = 320,
  parameter int          V_TOTAL  = 280,
  parameter int          HS_START = 272,
  parameter int          HS_LEN   = 24,
  parameter int          VS_START = 264,
  parameter int          VS_LEN   = 3,
  parameter logic [23:0] ON_RGB   = 24'h202020,
  parameter logic [23:0] OFF_RGB  = 24'hB0C0A0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lcd_enable,
  input  logic        lcd_flip,
  output logic        fb_rd,
  output logic [4:0]  fb_addr,
  input  logic [31:0] fb_data,
  output logic        ce_pix,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        vbl_irq
);

  localparam int ACT = 32 * SCALE;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int CW  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int SH  = $clog2(SCALE);

  localparam logic [CW-1:0] CE_LAST    = CW'(CE_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(ACT);
  localparam logic [HW-1:0] HS_BEG     = HW'(HS_START);
  localparam logic [HW-1:0] HS_END     = HW'(HS_START + HS_LEN);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(ACT);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(ACT - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(VS_START);
  localparam logic [VW-1:0] VS_END     = VW'(VS_START + VS_LEN);
  localparam logic [VW-1:0] SC_MASK    = VW'(SCALE - 1);

  logic [CW-1:0] ce_cnt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0]   row_buf;
  logic          rd_pend;
  logic          en_q;
  logic          flip_q;

  logic          h_last;
  logic [VW-1:0] nv;
  logic [4:0]    nrow;
  logic          line_fetch;
  logic [4:0]    col;
  logic          pix_bit;
  logic [23:0]   rgb_c;

  // Row fetch request: issued on the last ce of a line when the next line starts a new LCD row.
  always_comb begin
    h_last     = ce_pix && (hcnt == H_LAST);
    nv         = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    nrow       = 5'(nv >> SH);
    line_fetch = reset_n && h_last && (nv < V_ACT) && ((nv & SC_MASK) == '0);
    fb_rd      = line_fetch;
    fb_addr    = line_fetch ? (flip_q ? ~nrow : nrow) : 5'd0;
  end

  // Pixel colour for the current counter position; flip mirrors the column (31-col == ~col).
  always_comb begin
    col     = 5'(hcnt >> SH);
    pix_bit = flip_q ? row_buf[~col] : row_buf[col];
    rgb_c   = 24'h0;
    if ((hcnt < H_ACT) && (vcnt < V_ACT)) begin
      rgb_c = (pix_bit && en_q) ? ON_RGB : OFF_RGB;
    end
  end

  // Pixel-enable divider: ce_pix is high for one clk out of every CE_DIV, first clk after release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ce_cnt <= '0;
      ce_pix <= 1'b0;
    end else begin
      ce_pix <= (ce_cnt == '0);
      ce_cnt <= (ce_cnt == CE_LAST) ? '0 : ce_cnt + CW'(1);
    end
  end

  // Raster counters, advanced only on pixel enables.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce_pix) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= nv;
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Capture the framebuffer row one clk after the read strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      row_buf <= '0;
    end else begin
      rd_pend <= fb_rd;
      if (rd_pend) begin
        row_buf <= fb_data;
      end
    end
  end

  // Latch enable/flip as the frame enters vblank so mid-frame changes never tear; pulse the IRQ then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      flip_q  <= 1'b0;
      vbl_irq <= 1'b0;
    end else begin
      vbl_irq <= 1'b0;
      if (h_last && (vcnt == V_ACT_LAST)) begin
        en_q    <= lcd_enable;
        flip_q  <= lcd_flip;
        vbl_irq <= 1'b1;
      end
    end
  end

  // Registered video outputs, one pixel enable behind the counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      hblank    <= 1'b0;
      vblank    <= 1'b0;
      {r, g, b} <= 24'h0;
    end else if (ce_pix) begin
      hblank    <= !(hcnt < H_ACT);
      vblank    <= !(vcnt < V_ACT);
      hsync     <= (hcnt >= HS_BEG) && (hcnt < HS_END);
      vsync     <= (vcnt >= VS_BEG) && (vcnt < VS_END);
      {r, g, b} <= rgb_c;
    end
  end

endmodule

// File: tb/tb_pockstat_lcd_scan.sv
// tb_pockstat_lcd_scan: directed frame sequence against a reduced raster (CE_DIV=2, SCALE=2, 72x70).
// A negedge monitor compares every video sample and read strobe with a position model; fb_addr is
// checked against a queue of expected row addresses pushed when each frame's enable/flip is driven.
module tb_pockstat_lcd_scan;

  localparam int CE_DIV   = 2;
  localparam int SCALE    = 2;
  localparam int H_TOTAL  = 72;
  localparam int V_TOTAL  = 70;
  localparam int HS_START = 66;
  localparam int HS_LEN   = 3;
  localparam int VS_START = 66;
  localparam int VS_LEN   = 2;
  localparam int ACT      = 32 * SCALE;
  localparam int LIT_PER_FRAME = 33 * SCALE * SCALE;
  localparam logic [23:0] ON  = 24'h202020;
  localparam logic [23:0] OFF = 24'hB0C0A0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lcd_enable;
  logic        lcd_flip;
  logic        fb_rd;
  logic [4:0]  fb_addr;
  logic [31:0] fb_data;
  logic        ce_pix;
  logic        hsync, vsync, hblank, vblank;
  logic [7:0]  r, g, b;
  logic        vbl_irq;

  always #5 clk = ~clk;

  pockstat_lcd_scan #(
    .CE_DIV(CE_DIV), .SCALE(SCALE), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .HS_START(HS_START), .HS_LEN(HS_LEN), .VS_START(VS_START), .VS_LEN(VS_LEN),
    .ON_RGB(ON), .OFF_RGB(OFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lcd_enable(lcd_enable), .lcd_flip(lcd_flip),
    .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data), .ce_pix(ce_pix),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .r(r), .g(g), .b(b), .vbl_irq(vbl_irq)
  );

  // Framebuffer: data valid exactly one clk after the strobe, garbage otherwise.
  logic [31:0] mem [32];
  always @(posedge clk) fb_data <= fb_rd ? mem[fb_addr] : $urandom();

  int n_tests = 0;
  int n_fail  = 0;
  int addr_q[$];

  int ch, cv, vh, vv, nv, lx, ly, ea;
  bit vpend;
  logic m_en, m_flip;
  logic e_bit, e_hs, e_vs, e_hb, e_vb, e_irq, e_rd;
  logic [23:0] e_rgb;
  logic [31:0] row_w;
  int vid_err = 0, rd_err = 0, irq_err = 0;
  int rd_cnt = 0, irq_cnt = 0, lit_cnt = 0, ce_cnt = 0;
  int s_rd, s_irq, s_lit, s_ce;

  // Monitor: (ch,cv) mirrors the position the DUT will process at the next ce edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      ch = 0; cv = 0; vpend = 0; m_en = 0; m_flip = 0;
      if (fb_rd !== 1'b0) rd_err++;
    end else begin
      if (vpend) begin
        e_rgb = 24'h0;
        if (vh < ACT && vv < ACT) begin
          lx = vh / SCALE;
          ly = vv / SCALE;
          row_w = m_flip ? mem[31 - ly] : mem[ly];
          e_bit = m_flip ? row_w[31 - lx] : row_w[lx];
          e_rgb = (m_en && e_bit) ? ON : OFF;
        end
        e_hs = (vh >= HS_START) && (vh < HS_START + HS_LEN);
        e_vs = (vv >= VS_START) && (vv < VS_START + VS_LEN);
        e_hb = (vh >= ACT);
        e_vb = (vv >= ACT);
        if ({hsync, vsync, hblank, vblank} !== {e_hs, e_vs, e_hb, e_vb} || {r, g, b} !== e_rgb) begin
          vid_err++;
          if (vid_err <= 5)
            $display("[TB] video diff at h=%0d v=%0d: got hs%b vs%b hb%b vb%b rgb %h, want hs%b vs%b hb%b vb%b rgb %h",
                     vh, vv, hsync, vsync, hblank, vblank, {r, g, b}, e_hs, e_vs, e_hb, e_vb, e_rgb);
        end
        if ({r, g, b} === ON) lit_cnt++;
        if (vh == H_TOTAL - 1 && vv == ACT - 1) begin
          m_en = lcd_enable;
          m_flip = lcd_flip;
        end
      end
      e_irq = vpend && (vh == H_TOTAL - 1) && (vv == ACT - 1);
      if (vbl_irq !== e_irq) irq_err++;
      if (vbl_irq === 1'b1) irq_cnt++;
      nv = (cv == V_TOTAL - 1) ? 0 : cv + 1;
      e_rd = ce_pix && (ch == H_TOTAL - 1) && (nv < ACT) && ((nv % SCALE) == 0);
      if (fb_rd !== e_rd) rd_err++;
      if (fb_rd === 1'b1) begin
        rd_cnt++;
        if (addr_q.size() == 0) rd_err++;
        else begin
          ea = addr_q.pop_front();
          if (fb_addr !== 5'(ea)) rd_err++;
        end
      end
      vpend = ce_pix;
      if (ce_pix) begin
        vh = ch; vv = cv; ce_cnt++;
        if (ch == H_TOTAL - 1) begin
          ch = 0;
          cv = (cv == V_TOTAL - 1) ? 0 : cv + 1;
        end else ch++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rows(input bit rev, input int first);
    for (int i = first; i < 32; i++) addr_q.push_back(rev ? 31 - i : i);
  endtask

  task automatic snap();
    s_rd = rd_cnt; s_irq = irq_cnt; s_lit = lit_cnt; s_ce = ce_cnt;
  endtask

  task automatic wait_pos(input int h, input int v);
    bit hit = 0;
    for (int i = 0; i < 12000 && !hit; i++) begin
      @(posedge clk);
      if (ch == h && cv == v) hit = 1;
    end
    chk($sformatf("reach_%0d_%0d", h, v), 32'(hit), 32'd1);
    #1;
  endtask

  task automatic frame_check(input string tag, input int rd, input int irq, input int lit, input int ce);
    chk({tag, "_reads"}, 32'(rd_cnt - s_rd), 32'(rd));
    chk({tag, "_irqs"}, 32'(irq_cnt - s_irq), 32'(irq));
    chk({tag, "_lit"}, 32'(lit_cnt - s_lit), 32'(lit));
    chk({tag, "_ce"}, 32'(ce_cnt - s_ce), 32'(ce));
    chk({tag, "_video_diffs"}, 32'(vid_err), 32'd0);
    chk({tag, "_read_diffs"}, 32'(rd_err), 32'd0);
    chk({tag, "_irq_diffs"}, 32'(irq_err), 32'd0);
    snap();
  endtask

  // Called #1 after a posedge; holds reset for n edges and checks the quiet outputs.
  task automatic do_reset(input int n);
    bit rd_seen = 0;
    reset_n = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      rd_seen |= fb_rd;
    end
    chk("rst_no_rd", 32'(rd_seen), 32'd0);
    chk("rst_ctl", 32'({ce_pix, fb_rd, fb_addr, hsync, vsync, hblank, vblank, vbl_irq}), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    addr_q.delete();
    push_rows(1'b0, 1);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    snap();
    @(posedge clk); #1;
    chk("rel_ce_clk1", 32'(ce_pix), 32'd1);
    chk("rel_video_clk1", 32'({hsync, vsync, hblank, vblank, vbl_irq, r, g, b}), 32'd0);
    @(posedge clk); #1;
    chk("rel_ce_clk2", 32'(ce_pix), 32'd0);
    chk("rel_first_pix", 32'({hblank, vblank, r, g, b}), 32'({2'b00, OFF}));
    @(posedge clk); #1;
    chk("rel_ce_clk3", 32'(ce_pix), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    lcd_enable = 1'b1;
    lcd_flip = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1 << i;
    mem[3] = mem[3] | 32'h0010_0000;
    @(posedge clk); #1;
    do_reset(10);
    push_rows(1'b0, 0);
    release_reset();

    // Partial frame after release: rows 1..31 fetched, display off until the first latch.
    wait_pos(0, ACT);
    frame_check("f0", 31, 0, 0, ACT * H_TOTAL);

    // Frame 1 lit unflipped; request flip for frame 2.
    wait_pos(0, 20);
    lcd_flip = 1'b1;
    push_rows(1'b1, 0);
    wait_pos(0, ACT);
    frame_check("f1", 32, 1, LIT_PER_FRAME, H_TOTAL * V_TOTAL);

    // Frame 2 flipped; disable mid-frame, it must stay lit.
    wait_pos(0, 20);
    lcd_enable = 1'b0;
    lcd_flip = 1'b0;
    push_rows(1'b0, 0);
    wait_pos(0, ACT);
    frame_check("f2", 32, 1, LIT_PER_FRAME, H_TOTAL * V_TOTAL);

    // Frame 3 dark but still fetching; reset partway through.
    wait_pos(0, 30);
    chk("f3_reads", 32'(rd_cnt - s_rd), 32'd16);
    chk("f3_irqs", 32'(irq_cnt - s_irq), 32'd1);
    chk("f3_lit", 32'(lit_cnt - s_lit), 32'd0);
    chk("f3_queue", 32'(addr_q.size()), 32'd16);
    chk("f3_video_diffs", 32'(vid_err), 32'd0);
    lcd_enable = 1'b1;
    do_reset(5);
    push_rows(1'b0, 0);
    release_reset();

    wait_pos(0, ACT);
    frame_check("r0", 31, 0, 0, ACT * H_TOTAL);
    wait_pos(0, 20);
    wait_pos(0, ACT);
    frame_check("r1", 32, 1, LIT_PER_FRAME, H_TOTAL * V_TOTAL);
    chk("queue_drained", 32'(addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
